// File: rtl/ysyx_22041461_pkg.sv
// Shared definitions for the ysyx_22041461 fetch front end: IFU states,
// the default reset vector and the redirect-source encoding used with the CSR unit.
package ysyx_22041461_pkg;

    localparam logic [63:0] RESET_VEC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } ifu_state_e;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_TRAP = 2'd1,
        REDIR_MRET = 2'd2,
        REDIR_BR   = 2'd3
    } redir_src_e;

    // Fixed redirect priority: a trap beats mret, which beats a branch.
    function automatic redir_src_e redir_prio(input logic trap, input logic mret, input logic br);
        if (trap) return REDIR_TRAP;
        if (mret) return REDIR_MRET;
        if (br)   return REDIR_BR;
        return REDIR_NONE;
    endfunction

endpackage

// File: rtl/ysyx_22041461_redir_sel.sv
// Combinational redirect priority select: picks trap, mret or branch target
// and forces the result to a 4-byte aligned address.
module ysyx_22041461_redir_sel
    import ysyx_22041461_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            trap_valid,
    input  logic [XLEN-1:0] mtvec,
    input  logic            mret_valid,
    input  logic [XLEN-1:0] mepc,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    output logic            redir,
    output logic [XLEN-1:0] target
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

    redir_src_e      src;
    logic [XLEN-1:0] raw;

    always_comb begin
        src = redir_prio(trap_valid, mret_valid, br_valid);
        raw = '0;
        case (src)
            REDIR_TRAP: raw = mtvec;
            REDIR_MRET: raw = mepc;
            REDIR_BR:   raw = br_target;
            default:    raw = '0;
        endcase
    end

    assign redir  = (src != REDIR_NONE);
    assign target = raw & ALIGN_MASK;

endmodule

// File: rtl/ysyx_22041461_ifu_pc.sv
// PC generator and single-outstanding fetch sequencer for the ysyx_22041461 IFU.
// Handshakes: req (req_valid/req_ready), rsp (rsp_valid, no backpressure), inst (inst_valid/inst_ready).
module ysyx_22041461_ifu_pc
    import ysyx_22041461_pkg::*;
#(
    parameter int          XLEN      = 64,
    parameter logic [63:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter int          ILEN      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic [XLEN-1:0]  br_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  mtvec,
    input  logic             mret_valid,
    input  logic [XLEN-1:0]  mepc,
    output logic             req_valid,
    output logic [XLEN-1:0]  req_addr,
    input  logic             req_ready,
    input  logic             rsp_valid,
    input  logic [ILEN-1:0]  rsp_inst,
    output logic             inst_valid,
    output logic [ILEN-1:0]  inst,
    output logic [XLEN-1:0]  inst_pc,
    input  logic             inst_ready,
    output logic [XLEN-1:0]  snpc,
    output logic [XLEN-1:0]  pc,
    output ifu_state_e       dbg_state
);

    localparam logic [XLEN-1:0] STEP    = XLEN'(ILEN / 8);
    localparam logic [XLEN-1:0] PC_INIT = RESET_VEC[XLEN-1:0];

    ifu_state_e      state;
    logic            drop;
    logic            redir;
    logic [XLEN-1:0] target;

    ysyx_22041461_redir_sel #(
        .XLEN (XLEN)
    ) u_redir_sel (
        .trap_valid (trap_valid),
        .mtvec      (mtvec),
        .mret_valid (mret_valid),
        .mepc       (mepc),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .redir      (redir),
        .target     (target)
    );

    assign req_valid = (state == S_REQ) && !rst;
    assign req_addr  = pc;
    assign snpc      = pc + STEP;
    assign dbg_state = state;

    // drop marks an in-flight fetch whose address was superseded by a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= PC_INIT;
            drop       <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redir) pc <= target;
                    if (req_ready) begin
                        state <= S_WAIT;
                        if (redir) drop <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        if (drop || redir) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                            if (redir) pc <= target;
                        end else begin
                            inst       <= rsp_inst;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            state      <= S_OUT;
                        end
                    end else if (redir) begin
                        pc   <= target;
                        drop <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (redir) begin
                        pc         <= target;
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
                    end else if (inst_ready) begin
                        pc         <= snpc;
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                default: begin
                    state      <= S_REQ;
                    drop       <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041461_ifu_pc.sv
// Bench for ysyx_22041461_ifu_pc: directed scenarios then randomized traffic,
// checked every cycle against a transaction-level fetch model and a memory image.
module tb_ysyx_22041461_ifu_pc;
    import ysyx_22041461_pkg::*;

    logic        clk;
    logic        rst;
    logic        br_valid, trap_valid, mret_valid;
    logic [63:0] br_target, mtvec, mepc;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_inst;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc, snpc, pc;
    ifu_state_e  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_22041461_ifu_pc dut (
        .clk        (clk),
        .rst        (rst),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .trap_valid (trap_valid),
        .mtvec      (mtvec),
        .mret_valid (mret_valid),
        .mepc       (mepc),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_inst   (rsp_inst),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .snpc       (snpc),
        .pc         (pc),
        .dbg_state  (dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory image: each word is a fixed function of its address
    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [31:0] lo;
        lo = 32'h8000_0000 | 32'($urandom_range(0, 4095));
        return {($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'h0000_0000, lo};
    endfunction

    // transaction-level model: architectural pc, one outstanding fetch, one held instruction
    logic [63:0] m_pc        = 64'h8000_0000;
    logic        m_busy      = 1'b0;
    logic        m_stale     = 1'b0;
    logic        m_hold      = 1'b0;
    logic [31:0] m_hold_inst = '0;
    logic [63:0] m_hold_pc   = '0;

    // memory responder state
    logic        mem_pend = 1'b0;
    logic [63:0] mem_addr = '0;
    int          mem_lat  = 0;
    int          lat_min  = 0;
    int          lat_max  = 0;
    logic        spur_en  = 1'b0;

    task automatic idle_redirects();
        br_valid   = 1'b0;
        trap_valid = 1'b0;
        mret_valid = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("req_valid", 64'(req_valid), 64'(!rst && !m_busy && !m_hold));
        check_eq("pc", pc, m_pc);
        check_eq("req_addr", req_addr, m_pc);
        check_eq("snpc", snpc, m_pc + 64'd4);
        check_eq("inst_valid", 64'(inst_valid), 64'(m_hold));
        if (m_hold) begin
            check_eq("inst", 64'(inst), 64'(m_hold_inst));
            check_eq("inst_pc", inst_pc, m_hold_pc);
            check_eq("inst_mem", 64'(inst), 64'(mem_fn(m_hold_pc)));
        end
    endtask

    // One clock: drive the memory response, advance the model, check at the falling edge.
    task automatic tick();
        logic        redir, requesting, hs;
        logic [63:0] tgt, n_pc, n_hold_pc, old_pc;
        logic        n_busy, n_stale, n_hold;
        logic [31:0] n_hold_inst;

        rsp_valid = 1'b0;
        rsp_inst  = $urandom;
        if (mem_pend) begin
            if (mem_lat == 0) begin
                rsp_valid = 1'b1;
                rsp_inst  = mem_fn(mem_addr);
                mem_pend  = 1'b0;
            end else begin
                mem_lat--;
            end
        end else if (spur_en && !m_busy && $urandom_range(0, 7) == 0) begin
            rsp_valid = 1'b1;
        end

        redir = trap_valid || mret_valid || br_valid;
        tgt   = trap_valid ? mtvec : (mret_valid ? mepc : br_target);
        tgt   = {tgt[63:2], 2'b00};
        requesting = !m_busy && !m_hold;
        hs = !rst && requesting && req_ready;
        old_pc = m_pc;
        n_pc = m_pc; n_busy = m_busy; n_stale = m_stale; n_hold = m_hold;
        n_hold_inst = m_hold_inst; n_hold_pc = m_hold_pc;

        if (rst) begin
            n_pc = 64'h8000_0000; n_busy = 1'b0; n_stale = 1'b0; n_hold = 1'b0;
            n_hold_inst = '0; n_hold_pc = '0;
        end else if (requesting) begin
            if (req_ready) begin
                n_busy  = 1'b1;
                n_stale = redir;
            end
            if (redir) n_pc = tgt;
        end else if (m_busy) begin
            if (rsp_valid) begin
                if (!m_stale && !redir) begin
                    n_hold = 1'b1; n_hold_inst = rsp_inst; n_hold_pc = m_pc;
                end
                n_busy = 1'b0; n_stale = 1'b0;
            end else if (redir) begin
                n_stale = 1'b1;
            end
            if (redir) n_pc = tgt;
        end else begin
            if (redir) begin
                n_hold = 1'b0; n_pc = tgt;
            end else if (inst_ready) begin
                n_hold = 1'b0; n_pc = m_pc + 64'd4;
            end
        end

        @(posedge clk);
        m_pc = n_pc; m_busy = n_busy; m_stale = n_stale; m_hold = n_hold;
        m_hold_inst = n_hold_inst; m_hold_pc = n_hold_pc;
        if (hs) begin
            mem_pend = 1'b1;
            mem_addr = old_pc;
            mem_lat  = $urandom_range(lat_min, lat_max);
        end
        @(negedge clk);
        check_outputs();
    endtask

    // Tick until a request is visible; returns whether an instruction appeared meanwhile.
    task automatic wait_req(input string tag, output logic saw_inst);
        int n;
        saw_inst = 1'b0;
        n = 0;
        while (!req_valid && n < 20) begin
            tick();
            if (inst_valid) saw_inst = 1'b1;
            n++;
        end
        if (!req_valid) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    logic [63:0] seen_pc[3];
    int          seen_cyc[3];
    int          n_seen;
    logic        saw;

    initial begin
        idle_redirects();
        br_target = '0; mtvec = '0; mepc = '0;
        rsp_valid = 1'b0; rsp_inst = '0;
        rst = 1'b1; req_ready = 1'b0; inst_ready = 1'b0;
        @(negedge clk);

        // reset values
        repeat (3) tick();
        check_eq("rst_inst", 64'(inst), 64'd0);
        check_eq("rst_inst_pc", inst_pc, 64'd0);
        check_eq("rst_pc", pc, 64'h8000_0000);
        check_eq("rst_req_valid", 64'(req_valid), 64'd0);

        // first cycle after release, memory not yet ready
        rst = 1'b0;
        tick();
        check_eq("first_req_valid", 64'(req_valid), 64'd1);
        check_eq("first_req_addr", req_addr, 64'h8000_0000);

        // zero-wait memory: one instruction every 3 cycles
        req_ready = 1'b1; inst_ready = 1'b1; n_seen = 0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (inst_valid && n_seen < 3) begin
                seen_pc[n_seen]  = inst_pc;
                seen_cyc[n_seen] = c;
                n_seen++;
            end
        end
        check_eq("zw_count", 64'(n_seen), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq("zw_inst_pc", seen_pc[i], 64'h8000_0000 + 64'(4 * i));
            check_eq("zw_cycle", 64'(seen_cyc[i]), 64'(2 + 3 * i));
        end

        // branch while the fetch is in flight
        lat_min = 2; lat_max = 2;
        tick();
        br_valid = 1'b1; br_target = 64'h8000_0102;
        tick();
        idle_redirects();
        wait_req("br", saw);
        check_eq("br_no_inst", 64'(saw), 64'd0);
        check_eq("br_req_addr", req_addr, 64'h8000_0100);

        // all three redirect sources at once
        req_ready = 1'b0;
        trap_valid = 1'b1; mret_valid = 1'b1; br_valid = 1'b1;
        mtvec = 64'h8000_1000; mepc = 64'h8000_2000; br_target = 64'h8000_3000;
        tick();
        idle_redirects();
        check_eq("prio_req_valid", 64'(req_valid), 64'd1);
        check_eq("prio_req_addr", req_addr, 64'h8000_1000);

        // decode stalls for 10 cycles
        lat_min = 0; lat_max = 0;
        req_ready = 1'b1; inst_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("stall_inst_valid", 64'(inst_valid), 64'd1);
            check_eq("stall_inst_pc", inst_pc, 64'h8000_1000);
            check_eq("stall_inst", 64'(inst), 64'(mem_fn(64'h8000_1000)));
            check_eq("stall_req_valid", 64'(req_valid), 64'd0);
        end
        inst_ready = 1'b1;
        tick();
        check_eq("stall_next_addr", req_addr, 64'h8000_1004);

        // pc wraps at the top of the address space
        req_ready = 1'b0;
        br_valid = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        idle_redirects();
        check_eq("wrap_snpc", snpc, 64'd0);
        req_ready = 1'b1;
        tick(); tick();
        check_eq("wrap_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check_eq("wrap_req_valid", 64'(req_valid), 64'd1);
        check_eq("wrap_req_addr", req_addr, 64'd0);

        // reset while waiting for a response; the late response must be ignored
        lat_min = 3; lat_max = 3;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("rstw_inst_valid", 64'(inst_valid), 64'd0);
        end
        check_eq("rstw_pc", pc, 64'h8000_0000);

        // randomized traffic
        spur_en = 1'b1; lat_min = 0; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            req_ready  = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 2) != 0);
            trap_valid = ($urandom_range(0, 39) == 0);
            mret_valid = ($urandom_range(0, 29) == 0);
            br_valid   = ($urandom_range(0, 9) == 0);
            mtvec      = rand_target();
            mepc       = rand_target();
            br_target  = rand_target();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
